// File: rtl/fetch_unit.sv
// Instruction fetch responder for the multi-cycle core.
// Accepts fetch requests, issues a single read at the current PC, waits the
// fixed memory latency, latches the word into the IR and raises fetch_done.
// Also owns the PC (sequential increment and branch load).
module fetch_unit #(
  parameter bit              DEBUG       = 1'b0,
  parameter int              ADDR_W      = 16,
  parameter int              DATA_W      = 16,
  parameter int              MEM_LATENCY = 2,     // must be >= 1
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int              PC_INC      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              pc_fetch_wr,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic [3:0]        fetch_state_reg
);

  // Countdown holds MEM_LATENCY-1; keep at least one bit for latency 1.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_WAIT = 4'b0010,
    S_DONE = 4'b0100,
    S_ERR  = 4'b1000
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  // PC register: branch load beats sequential increment; adder wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)            pc <= RESET_PC;
    else if (pc_load)     pc <= pc_in;
    else if (pc_fetch_wr) pc <= pc + ADDR_W'(PC_INC);
  end

  // Fetch FSM: address/strobe/IR/status are all registered here. The address
  // is latched at request time so later PC updates never disturb a fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      instr      <= '0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (fetch_en) begin
            fetch_done <= 1'b0;
            if (pc[0]) begin
              // Misaligned: no read; report the error on the next edge.
              state <= S_ERR;
            end else begin
              mem_addr  <= pc;
              mem_rd_en <= 1'b1;
              fetch_err <= 1'b0;
              count     <= CNT_W'(MEM_LATENCY - 1);
              state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Requests arriving here are dropped, not queued.
          if (count == '0) begin
            instr      <= mem_rdata;
            fetch_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_ERR: begin
          fetch_err  <= 1'b1;
          fetch_done <= 1'b1;
          state      <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fetch_state_reg = DEBUG ? state : 4'b0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance at latency 2, one at latency 4,
// sharing inputs and a behavioural instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, fetch_en, pc_fetch_wr, pc_load;
  logic [15:0] pc_in;

  logic [15:0] mem_addr2, instr2, pc2, rdata2;
  logic        rd_en2, done2, err2;
  logic [3:0]  st2;
  logic [15:0] mem_addr4, instr4, pc4, rdata4;
  logic        rd_en4, done4, err4;
  logic [3:0]  st4;

  logic [15:0] mem [0:255];

  int tests  = 0;
  int failed = 0;

  localparam logic [3:0] ST_IDLE = 4'b0001, ST_WAIT = 4'b0010,
                         ST_DONE = 4'b0100, ST_ERR  = 4'b1000;

  always #5 clk = ~clk;

  assign rdata2 = mem[mem_addr2[7:0]];
  assign rdata4 = mem[mem_addr4[7:0]];

  fetch_unit #(.DEBUG(1'b1), .MEM_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_fetch_wr(pc_fetch_wr),
    .pc_load(pc_load), .pc_in(pc_in), .mem_rdata(rdata2), .mem_addr(mem_addr2),
    .mem_rd_en(rd_en2), .instr(instr2), .pc(pc2), .fetch_done(done2),
    .fetch_err(err2), .fetch_state_reg(st2));

  fetch_unit #(.DEBUG(1'b1), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_fetch_wr(pc_fetch_wr),
    .pc_load(pc_load), .pc_in(pc_in), .mem_rdata(rdata4), .mem_addr(mem_addr4),
    .mem_rd_en(rd_en4), .instr(instr4), .pc(pc4), .fetch_done(done4),
    .fetch_err(err4), .fetch_state_reg(st4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
    mem[8'h00] = 16'hA5C3;
    mem[8'h02] = 16'h3C5A;
    mem[8'h04] = 16'h0F0F;
    mem[8'h10] = 16'h1234;

    reset = 1'b1; fetch_en = 1'b0; pc_fetch_wr = 1'b0; pc_load = 1'b0; pc_in = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_pc",    pc2,    16'h0000);
    check("rst_addr",  mem_addr2, 16'h0000);
    check("rst_rd",    rd_en2, 1'b0);
    check("rst_instr", instr2, 16'h0000);
    check("rst_done",  done2,  1'b0);
    check("rst_err",   err2,   1'b0);
    check("rst_state", st2,    ST_IDLE);

    // 1: basic fetch at pc=0, latency 2
    fetch_en = 1'b1;
    tick();                                   // T0
    fetch_en = 1'b0;
    check("t1_rd_T0+1",   rd_en2,    1'b1);
    check("t1_addr",      mem_addr2, 16'h0000);
    check("t1_done_T0+1", done2,     1'b0);
    check("t1_state_w",   st2,       ST_WAIT);
    tick();
    check("t1_rd_T0+2",   rd_en2,    1'b0);
    check("t1_done_mid",  done2,     1'b0);
    tick();
    check("t1_done",      done2,     1'b1);
    check("t1_instr",     instr2,    16'hA5C3);
    check("t1_err",       err2,      1'b0);
    check("t1_state_d",   st2,       ST_DONE);

    // 2: PC wrap and load priority
    pc_load = 1'b1; pc_in = 16'hFFFC;
    tick();
    pc_load = 1'b0;
    check("t2_load", pc2, 16'hFFFC);
    pc_fetch_wr = 1'b1;
    tick(); check("t2_inc1", pc2, 16'hFFFE);
    tick(); check("t2_wrap", pc2, 16'h0000);
    tick(); check("t2_inc3", pc2, 16'h0002);
    pc_load = 1'b1; pc_in = 16'h0100;
    tick();
    pc_load = 1'b0; pc_fetch_wr = 1'b0;
    check("t2_prio", pc2, 16'h0100);
    check("t2_done_held", done2, 1'b1);
    check("t2_instr_held", instr2, 16'hA5C3);

    // 3: misaligned fetch
    pc_load = 1'b1; pc_in = 16'h0101;
    tick();
    pc_load = 1'b0;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("t3_no_rd",    rd_en2, 1'b0);
    check("t3_done_clr", done2,  1'b0);
    check("t3_state_e",  st2,    ST_ERR);
    tick();
    check("t3_rd",    rd_en2, 1'b0);
    check("t3_err",   err2,   1'b1);
    check("t3_done",  done2,  1'b1);
    check("t3_instr", instr2, 16'hA5C3);

    // 4: latency 4, re-pulsed requests during WAIT are ignored
    pc_load = 1'b1; pc_in = 16'h0010;
    tick();
    pc_load = 1'b0;
    fetch_en = 1'b1;
    tick();                                   // T0
    check("t4_rd",      rd_en4,    1'b1);
    check("t4_addr",    mem_addr4, 16'h0010);
    check("t4_err_clr", err4,      1'b0);
    tick();                                   // T0+1 (fetch_en still high)
    check("t4_rd1",     rd_en4,    1'b0);
    tick();                                   // T0+2
    fetch_en = 1'b0;
    check("t4_rd2",     rd_en4,    1'b0);
    check("t4_done2",   done4,     1'b0);
    tick();                                   // T0+3
    check("t4_rd3",     rd_en4,    1'b0);
    check("t4_done3",   done4,     1'b0);
    tick();                                   // T0+4
    check("t4_done4",   done4,     1'b1);
    check("t4_instr",   instr4,    16'h1234);
    check("t4_state",   st4,       ST_DONE);

    // 5: reset mid-fetch aborts it
    pc_load = 1'b1; pc_in = 16'h0004;
    tick();
    pc_load = 1'b0;
    fetch_en = 1'b1;
    tick();                                   // T0
    fetch_en = 1'b0; reset = 1'b1;
    tick();                                   // T0+1
    reset = 1'b0;
    check("t5_done",  done2,  1'b0);
    check("t5_instr", instr2, 16'h0000);
    check("t5_pc",    pc2,    16'h0000);
    check("t5_state", st2,    ST_IDLE);
    tick(); tick();
    check("t5_no_done", done2, 1'b0);
    check("t5_no_rd",   rd_en2, 1'b0);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("t5_rd", rd_en2, 1'b1);
    tick(); tick();
    check("t5_done2",  done2,  1'b1);
    check("t5_instr2", instr2, 16'hA5C3);

    // 6: held fetch_en, PC stepped during each fetch -> words from 0, 2, 4
    fetch_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();                                 // request accepted
      check($sformatf("t6_addr%0d", k), mem_addr2, 16'(2 * k));
      check($sformatf("t6_rd%0d", k),   rd_en2,    1'b1);
      check($sformatf("t6_clr%0d", k),  done2,     1'b0);
      pc_fetch_wr = 1'b1;
      tick();
      pc_fetch_wr = 1'b0;
      check($sformatf("t6_mid%0d", k),  done2,     1'b0);
      tick();                                 // MEM_LATENCY edges after request
      check($sformatf("t6_done%0d", k), done2,     1'b1);
      check($sformatf("t6_hold%0d", k), mem_addr2, 16'(2 * k));
      check($sformatf("t6_ir%0d", k),   instr2,    mem[8'(2 * k)]);
    end
    fetch_en = 1'b0;
    check("t6_pc", pc2, 16'h0006);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
